// File: rtl/shift_serializer_pkg.sv
// Shared definitions for the shift_serializer block: FSM state encoding and
// the counter-width helper.
package shift_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Ceiling log2; callers guarantee n >= 2, so the result is at least 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_serializer_if.sv
// Bundle of the parallel-in / serial-out handshake signals of shift_serializer.
// A transfer happens on a rising clk edge where valid and ready are both 1;
// valid never waits for ready, and data is held while valid=1 and ready=0.
interface shift_serializer_if #(
   parameter int width = 8
);
   logic [width-1:0] iBits;
   logic             iValid;
   logic             iReady;
   logic             sBit;
   logic             sValid;
   logic             sLast;
   logic             sReady;

   // master: the environment (upstream producer plus downstream consumer)
   modport master (
      output iBits, iValid, sReady,
      input  iReady, sBit, sValid, sLast
   );

   // slave: the serializer itself
   modport slave (
      input  iBits, iValid, sReady,
      output iReady, sBit, sValid, sLast
   );
endinterface

// File: rtl/shift_serializer.sv
// Parallel-to-serial converter with valid/ready on both sides.
// Define SHIFT_SERIALIZER_BACK2BACK_EN to accept the next word on the last beat.
module shift_serializer
   import shift_serializer_pkg::*;
#(
   parameter int width    = 8,
   parameter bit msbFirst = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [width-1:0] iBits,
   input  logic             iValid,
   output logic             iReady,
   output logic             sBit,
   output logic             sValid,
   output logic             sLast,
   input  logic             sReady,
   output state_t           fsm_state
);

   localparam int CW = clog2(width);
   localparam logic [CW-1:0] LAST_CNT = CW'(width - 1);

   state_t           cur_state, state_nx;
   logic [width-1:0] shreg, shreg_nx;
   logic [CW-1:0]    cnt, cnt_nx;

   assign fsm_state = cur_state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cur_state <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
      end else begin
         cur_state <= state_nx;
         shreg     <= shreg_nx;
         cnt       <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = cur_state;
      shreg_nx = shreg;
      cnt_nx   = cnt;
      iReady   = 1'b0;
      sValid   = 1'b0;
      sLast    = (cur_state == SHIFT) && (cnt == LAST_CNT);
      sBit     = msbFirst ? shreg[width-1] : shreg[0];

      case (cur_state)
         IDLE: begin
            iReady = 1'b1;
         end
         SHIFT: begin
            sValid = 1'b1;
`ifdef SHIFT_SERIALIZER_BACK2BACK_EN
            // Only the final beat may overlap with the next load.
            iReady = sLast && sReady;
`endif
            if (sReady) begin
               shreg_nx = msbFirst ? (shreg << 1) : (shreg >> 1);
               cnt_nx   = cnt + CW'(1);
               if (sLast) state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      // A load overrides the shift of a concurrently completing word.
      if (iReady && iValid) begin
         shreg_nx = iBits;
         cnt_nx   = '0;
         state_nx = SHIFT;
      end
   end

endmodule

// File: tb/tb_shift_serializer.sv
// Self-checking bench for shift_serializer: three instances (MSB-first, LSB-first,
// width 2) driven through interfaces and checked against a bit-order model.
module tb_shift_serializer;
   import shift_serializer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   shift_serializer_if #(.width(8)) m_if ();
   shift_serializer_if #(.width(8)) l_if ();
   shift_serializer_if #(.width(2)) t_if ();
   state_t m_state, l_state, t_state;

   shift_serializer #(.width(8), .msbFirst(1'b1)) u_msb (
      .clk(clk), .rst(rst), .iBits(m_if.iBits), .iValid(m_if.iValid),
      .iReady(m_if.iReady), .sBit(m_if.sBit), .sValid(m_if.sValid),
      .sLast(m_if.sLast), .sReady(m_if.sReady), .fsm_state(m_state));

   shift_serializer #(.width(8), .msbFirst(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .iBits(l_if.iBits), .iValid(l_if.iValid),
      .iReady(l_if.iReady), .sBit(l_if.sBit), .sValid(l_if.sValid),
      .sLast(l_if.sLast), .sReady(l_if.sReady), .fsm_state(l_state));

   shift_serializer #(.width(2), .msbFirst(1'b1)) u_w2 (
      .clk(clk), .rst(rst), .iBits(t_if.iBits), .iValid(t_if.iValid),
      .iReady(t_if.iReady), .sBit(t_if.sBit), .sValid(t_if.sValid),
      .sLast(t_if.sLast), .sReady(t_if.sReady), .fsm_state(t_state));

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required finish before %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      m_if.iValid = 1'b0; m_if.iBits = '0; m_if.sReady = 1'b1;
      l_if.iValid = 1'b0; l_if.iBits = '0; l_if.sReady = 1'b1;
      t_if.iValid = 1'b0; t_if.iBits = '0; t_if.sReady = 1'b1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic model_bit(input logic [7:0] w, input int wd, input bit msb, input int k);
      return msb ? w[wd - 1 - k] : w[k];
   endfunction

   function automatic int wd_of(input int sel);
      return (sel == 2) ? 2 : 8;
   endfunction

   function automatic bit msb_of(input int sel);
      return (sel == 1) ? 1'b0 : 1'b1;
   endfunction

   // ---------------- driver / trace capture ----------------
   logic tr_iv[$], tr_ir[$], tr_sv[$], tr_sb[$], tr_sl[$], tr_sr[$];
   logic beat_q[$], beat_last_q[$];
   int   beat_cyc_q[$];
   logic exp_q[$];

   // mode 0: sReady=1; mode 1: sReady pattern 1,0,0,...; mode 2: random (mostly 1)
   task automatic drive(input int sel, input logic [7:0] words[$], input int mode, input int ncyc);
      int   wi;
      logic iv, sr, ir, sv, sb, sl;
      logic [7:0] w;
      wi = 0;
      tr_iv.delete(); tr_ir.delete(); tr_sv.delete(); tr_sb.delete(); tr_sl.delete(); tr_sr.delete();
      beat_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         iv = (wi < words.size());
         if (iv) w = words[wi];
         else w = 8'($urandom);
         case (mode)
            0: sr = 1'b1;
            1: sr = ((c % 3) == 0);
            default: sr = ($urandom_range(0, 3) != 0);
         endcase
         case (sel)
            0: begin m_if.iValid = iv; m_if.iBits = w; m_if.sReady = sr; end
            1: begin l_if.iValid = iv; l_if.iBits = w; l_if.sReady = sr; end
            default: begin t_if.iValid = iv; t_if.iBits = w[1:0]; t_if.sReady = sr; end
         endcase
         #1;
         case (sel)
            0: begin ir = m_if.iReady; sv = m_if.sValid; sb = m_if.sBit; sl = m_if.sLast; end
            1: begin ir = l_if.iReady; sv = l_if.sValid; sb = l_if.sBit; sl = l_if.sLast; end
            default: begin ir = t_if.iReady; sv = t_if.sValid; sb = t_if.sBit; sl = t_if.sLast; end
         endcase
         if (iv && ir) wi++;
         tr_iv.push_back(iv); tr_ir.push_back(ir); tr_sv.push_back(sv);
         tr_sb.push_back(sb); tr_sl.push_back(sl); tr_sr.push_back(sr);
         if (sv && sr) begin
            beat_q.push_back(sb);
            beat_last_q.push_back(sl);
            beat_cyc_q.push_back(c);
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (m_if.iReady !== 1'b1) begin n_fail++; $display("FAIL reset_iready: got %b want 1", m_if.iReady); end
      n_checks++;
      if (m_if.sValid !== 1'b0) begin n_fail++; $display("FAIL reset_svalid: got %b want 0", m_if.sValid); end
      n_checks++;
      if (m_if.sLast !== 1'b0) begin n_fail++; $display("FAIL reset_slast: got %b want 0", m_if.sLast); end
      n_checks++;
      if (m_if.sBit !== 1'b0) begin n_fail++; $display("FAIL reset_sbit: got %b want 0", m_if.sBit); end
      n_checks++;
      if (m_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", m_state); end
      n_checks++;
      if (l_if.sValid !== 1'b0 || t_if.sValid !== 1'b0) begin
         n_fail++; $display("FAIL reset_others: lsb sValid=%b w2 sValid=%b want 0", l_if.sValid, t_if.sValid);
      end
      rst = 1'b1;
   endtask

   task automatic test_msb_a5();
      logic [7:0] wq[$];
      int acc;
      apply_reset();
      wq = {8'hA5};
      drive(0, wq, 0, 12);
      acc = -1;
      for (int c = 0; c < tr_iv.size(); c++) if (acc < 0 && tr_iv[c] && tr_ir[c]) acc = c;
      n_checks++;
      if (acc !== 0) begin n_fail++; $display("FAIL a5_accept_cycle: got %0d want 0", acc); acc = 0; end
      for (int k = 1; k <= 8; k++) begin
         n_checks++;
         if (tr_sv[acc+k] !== 1'b1 || tr_sb[acc+k] !== model_bit(8'hA5, 8, 1'b1, k-1) || tr_sl[acc+k] !== (k == 8)) begin
            n_fail++;
            $display("FAIL a5_beat%0d: got v=%b b=%b l=%b want v=1 b=%b l=%b", k,
                     tr_sv[acc+k], tr_sb[acc+k], tr_sl[acc+k], model_bit(8'hA5, 8, 1'b1, k-1), (k == 8));
         end
      end
      for (int k = 1; k <= 7; k++) begin
         n_checks++;
         if (tr_ir[acc+k] !== 1'b0) begin n_fail++; $display("FAIL a5_iready_busy%0d: got %b want 0", k, tr_ir[acc+k]); end
      end
      n_checks++;
      if (tr_sv[acc+9] !== 1'b0) begin n_fail++; $display("FAIL a5_idle_after: sValid got %b want 0", tr_sv[acc+9]); end
   endtask

   task automatic test_lsb_01();
      logic [7:0] wq[$];
      logic want_ir_last;
      apply_reset();
      wq = {8'h01};
      drive(1, wq, 0, 12);
`ifdef SHIFT_SERIALIZER_BACK2BACK_EN
      want_ir_last = 1'b1;
`else
      want_ir_last = 1'b0;
`endif
      n_checks++;
      if (beat_q.size() != 8) begin n_fail++; $display("FAIL lsb_beat_count: got %0d want 8", beat_q.size()); end
      for (int k = 0; k < beat_q.size() && k < 8; k++) begin
         n_checks++;
         if (beat_q[k] !== (k == 0)) begin n_fail++; $display("FAIL lsb_bit%0d: got %b want %b", k, beat_q[k], (k == 0)); end
      end
      for (int k = 1; k <= 8; k++) begin
         n_checks++;
         if (tr_ir[k] !== ((k == 8) ? want_ir_last : 1'b0)) begin
            n_fail++; $display("FAIL lsb_iready_cyc%0d: got %b want %b", k, tr_ir[k], (k == 8) ? want_ir_last : 1'b0);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] wq[$];
      apply_reset();
      wq = {8'hF0};
      drive(0, wq, 1, 40);
      n_checks++;
      if (beat_q.size() != 8) begin n_fail++; $display("FAIL bp_beat_count: got %0d want 8", beat_q.size()); end
      for (int k = 0; k < beat_q.size() && k < 8; k++) begin
         n_checks++;
         if (beat_q[k] !== model_bit(8'hF0, 8, 1'b1, k) || beat_last_q[k] !== (k == 7)) begin
            n_fail++; $display("FAIL bp_beat%0d: got b=%b l=%b want b=%b l=%b", k, beat_q[k], beat_last_q[k],
                               model_bit(8'hF0, 8, 1'b1, k), (k == 7));
         end
      end
      for (int c = 0; c + 1 < tr_sv.size(); c++) begin
         if (tr_sv[c] && !tr_sr[c]) begin
            n_checks++;
            if (tr_sv[c+1] !== 1'b1 || tr_sb[c+1] !== tr_sb[c] || tr_sl[c+1] !== tr_sl[c]) begin
               n_fail++; $display("FAIL bp_stall_cyc%0d: got v=%b b=%b l=%b want v=1 b=%b l=%b", c,
                                  tr_sv[c+1], tr_sb[c+1], tr_sl[c+1], tr_sb[c], tr_sl[c]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] wq[$];
      int want_gap;
      apply_reset();
      wq = {8'hFF, 8'h00};
      drive(0, wq, 0, 24);
`ifdef SHIFT_SERIALIZER_BACK2BACK_EN
      want_gap = 1;
`else
      want_gap = 2;
`endif
      n_checks++;
      if (beat_q.size() != 16) begin
         n_fail++; $display("FAIL b2b_beat_count: got %0d want 16", beat_q.size());
      end else begin
         for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (beat_q[k] !== (k < 8) || beat_last_q[k] !== (k == 7 || k == 15)) begin
               n_fail++; $display("FAIL b2b_beat%0d: got b=%b l=%b want b=%b l=%b", k, beat_q[k], beat_last_q[k],
                                  (k < 8), (k == 7 || k == 15));
            end
         end
         n_checks++;
         if (beat_cyc_q[8] - beat_cyc_q[7] != want_gap) begin
            n_fail++; $display("FAIL b2b_gap: got %0d want %0d", beat_cyc_q[8] - beat_cyc_q[7], want_gap);
         end
         n_checks++;
         if (beat_cyc_q[7] - beat_cyc_q[0] != 7 || beat_cyc_q[15] - beat_cyc_q[8] != 7) begin
            n_fail++; $display("FAIL b2b_contiguous: got spans %0d,%0d want 7,7",
                               beat_cyc_q[7] - beat_cyc_q[0], beat_cyc_q[15] - beat_cyc_q[8]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] wq[$];
      logic [7:0] w;
      logic got[3];
      apply_reset();
      @(negedge clk);
      m_if.iValid = 1'b1; m_if.iBits = 8'hC3; m_if.sReady = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         m_if.iValid = 1'b0;
         #1;
         got[k] = m_if.sBit;
      end
      n_checks++;
      if ({got[0], got[1], got[2]} !== 3'b110) begin
         n_fail++; $display("FAIL rmid_first3: got %b%b%b want 110", got[0], got[1], got[2]);
      end
      @(negedge clk);
      rst = 1'b0;
      m_if.sReady = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      m_if.sReady = 1'b1;
      #1;
      n_checks++;
      if (m_if.sValid !== 1'b0 || m_if.iReady !== 1'b1 || m_if.sLast !== 1'b0) begin
         n_fail++; $display("FAIL rmid_after_reset: got sValid=%b iReady=%b sLast=%b want 0,1,0",
                            m_if.sValid, m_if.iReady, m_if.sLast);
      end
      w = 8'($urandom);
      wq = {w};
      drive(0, wq, 0, 12);
      n_checks++;
      if (beat_q.size() != 8) begin n_fail++; $display("FAIL rmid_next_count: got %0d want 8", beat_q.size()); end
      for (int k = 0; k < beat_q.size() && k < 8; k++) begin
         n_checks++;
         if (beat_q[k] !== model_bit(w, 8, 1'b1, k)) begin
            n_fail++; $display("FAIL rmid_next_bit%0d: got %b want %b (word %h)", k, beat_q[k], model_bit(w, 8, 1'b1, k), w);
         end
      end
   endtask

   task automatic test_width2();
      logic [7:0] wq[$];
      apply_reset();
      wq = {8'h02};
      drive(2, wq, 0, 6);
      n_checks++;
      if (beat_q.size() != 2) begin
         n_fail++; $display("FAIL w2_count: got %0d want 2", beat_q.size());
      end else begin
         n_checks++;
         if (beat_q[0] !== 1'b1 || beat_q[1] !== 1'b0 || beat_last_q[0] !== 1'b0 || beat_last_q[1] !== 1'b1) begin
            n_fail++; $display("FAIL w2_beats: got b=%b%b l=%b%b want b=10 l=01",
                               beat_q[0], beat_q[1], beat_last_q[0], beat_last_q[1]);
         end
         n_checks++;
         if (beat_cyc_q[0] != 1) begin n_fail++; $display("FAIL w2_latency: got %0d want 1", beat_cyc_q[0]); end
      end
   endtask

   task automatic test_random();
      logic [7:0] wq[$];
      logic [7:0] w;
      int wd, nexp;
      logic eb;
      for (int sel = 0; sel < 3; sel++) begin
         apply_reset();
         wq.delete();
         exp_q.delete();
         wd = wd_of(sel);
         for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            if (wd == 2) w = {6'b0, w[1:0]};
            wq.push_back(w);
            for (int k = 0; k < wd; k++) exp_q.push_back(model_bit(w, wd, msb_of(sel), k));
         end
         nexp = exp_q.size();
         drive(sel, wq, 2, 400);
         n_checks++;
         if (beat_q.size() != nexp) begin
            n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", sel, beat_q.size(), nexp);
         end
         for (int k = 0; k < beat_q.size() && exp_q.size() > 0; k++) begin
            eb = exp_q.pop_front();
            n_checks++;
            if (beat_q[k] !== eb || beat_last_q[k] !== ((k % wd) == wd - 1)) begin
               n_fail++; $display("FAIL rand%0d_beat%0d: got b=%b l=%b want b=%b l=%b", sel, k,
                                  beat_q[k], beat_last_q[k], eb, ((k % wd) == wd - 1));
            end
         end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_msb_a5();
      test_lsb_01();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_width2();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
